// File: rtl/eth_rx_frame_fifo.sv
// Receive frame FIFO for the RMII MAC.
// Incoming frames are buffered and are only made visible to the consumer after
// a good eof. Bad frames, truncated frames (a new sof arrives before the eof)
// and frames that overflow the buffer are discarded and counted in drop_cnt.
// The read side uses a registered RAM read followed by one output register.
module eth_rx_frame_fifo #(
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic             clk_mac,
   input  logic             rst,
   input  logic             in_vld,
   input  logic [7:0]       in_dat,
   input  logic             in_sof,
   input  logic             in_eof,
   input  logic             in_err,
   output logic             out_vld,
   output logic [7:0]       out_dat,
   output logic             out_sof,
   output logic             out_eof,
   input  logic             out_rdy,
   output logic [CNT_W-1:0] drop_cnt,
   output logic             ovf
);

   localparam int unsigned     DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_DROP
   } wstate_e;

   // Byte storage: {eof flag, data}
   logic [8:0]        ram_q [DEPTH];

   // Write side state
   wstate_e           state_q, state_d;
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   cmt_ptr_q, cmt_ptr_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic              ovf_q, ovf_d;

   // Read side state
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic              pf_vld_q, pf_vld_d;
   logic [8:0]        pf_dat_q;
   logic              out_vld_q, out_vld_d;
   logic [7:0]        out_dat_q, out_dat_d;
   logic              out_sof_q, out_sof_d;
   logic              out_eof_q, out_eof_d;
   logic              sof_next_q, sof_next_d;

   // Combinational helpers
   logic              full_wr;
   logic              full_cmt;
   logic              frame_start;
   logic [1:0]        drop_add;
   logic [CNT_W:0]    drop_sum;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [8:0]        mem_wdata;
   logic              out_load;
   logic              pf_load;
   logic              fetch;

   // Space checks from pre-edge pointers (rd_ptr only ever advances)
   always_comb begin
      full_wr  = (wr_ptr_q - rd_ptr_q) == PTR_FULL;
      full_cmt = (cmt_ptr_q - rd_ptr_q) == PTR_FULL;
   end

   // Write FSM: accept, commit, rewind or discard incoming bytes
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      cmt_ptr_d   = cmt_ptr_q;
      ovf_d       = 1'b0;
      drop_add    = 2'd0;
      mem_we      = 1'b0;
      mem_waddr   = wr_ptr_q[ADDR_W-1:0];
      mem_wdata   = {in_eof, in_dat};
      frame_start = 1'b0;

      if (in_vld) begin
         case (state_q)
            ST_IDLE: begin
               frame_start = in_sof;
            end
            ST_DROP: begin
               if (in_sof) begin
                  frame_start = 1'b1;
               end else if (in_eof) begin
                  state_d = ST_IDLE;
               end
            end
            ST_RECV: begin
               if (in_sof) begin
                  // Previous frame lost its eof: discard it and restart at cmt_ptr
                  drop_add    = 2'd1;
                  frame_start = 1'b1;
               end else if (full_wr) begin
                  wr_ptr_d = cmt_ptr_q;
                  ovf_d    = 1'b1;
                  drop_add = 2'd1;
                  state_d  = in_eof ? ST_IDLE : ST_DROP;
               end else begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_ONE;
                  if (in_eof) begin
                     state_d = ST_IDLE;
                     if (in_err) begin
                        wr_ptr_d = cmt_ptr_q;
                        drop_add = 2'd1;
                     end else begin
                        cmt_ptr_d = wr_ptr_q + PTR_ONE;
                     end
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase

         // A frame always starts at cmt_ptr; outside RECV wr_ptr already equals it
         if (frame_start) begin
            if (full_cmt) begin
               wr_ptr_d = cmt_ptr_q;
               ovf_d    = 1'b1;
               drop_add = drop_add + 2'd1;
               state_d  = in_eof ? ST_IDLE : ST_DROP;
            end else begin
               mem_we    = 1'b1;
               mem_waddr = cmt_ptr_q[ADDR_W-1:0];
               wr_ptr_d  = cmt_ptr_q + PTR_ONE;
               if (in_eof) begin
                  state_d = ST_IDLE;
                  if (in_err) begin
                     wr_ptr_d = cmt_ptr_q;
                     drop_add = drop_add + 2'd1;
                  end else begin
                     cmt_ptr_d = cmt_ptr_q + PTR_ONE;
                  end
               end else begin
                  state_d = ST_RECV;
               end
            end
         end
      end
   end

   // Saturating dropped-frame counter
   always_comb begin
      drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_add);
      drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
   end

   // Write side registers
   always_ff @(posedge clk_mac or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         cmt_ptr_q  <= '0;
         drop_cnt_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         cmt_ptr_q  <= cmt_ptr_d;
         drop_cnt_q <= drop_cnt_d;
         ovf_q      <= ovf_d;
      end
   end

   // RAM write port; contents need no reset
   always_ff @(posedge clk_mac) begin
      if (mem_we) begin
         ram_q[mem_waddr] <= mem_wdata;
      end
   end

   // Read pipeline control: prefetch register feeds the output register
   always_comb begin
      out_load   = !out_vld_q || out_rdy;
      pf_load    = !pf_vld_q || out_load;
      fetch      = (rd_ptr_q != cmt_ptr_q) && pf_load;
      rd_ptr_d   = fetch ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      pf_vld_d   = fetch || (pf_vld_q && !out_load);

      out_vld_d  = out_vld_q;
      out_dat_d  = out_dat_q;
      out_sof_d  = out_sof_q;
      out_eof_d  = out_eof_q;
      sof_next_d = sof_next_q;
      if (out_load) begin
         out_vld_d = pf_vld_q;
         if (pf_vld_q) begin
            out_dat_d  = pf_dat_q[7:0];
            out_eof_d  = pf_dat_q[8];
            out_sof_d  = sof_next_q;
            sof_next_d = pf_dat_q[8];
         end
      end
   end

   // Registered RAM read into the prefetch stage
   always_ff @(posedge clk_mac) begin
      if (fetch) begin
         pf_dat_q <= ram_q[rd_ptr_q[ADDR_W-1:0]];
      end
   end

   // Read side registers
   always_ff @(posedge clk_mac or posedge rst) begin
      if (rst) begin
         rd_ptr_q   <= '0;
         pf_vld_q   <= 1'b0;
         out_vld_q  <= 1'b0;
         out_dat_q  <= '0;
         out_sof_q  <= 1'b0;
         out_eof_q  <= 1'b0;
         sof_next_q <= 1'b1;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         pf_vld_q   <= pf_vld_d;
         out_vld_q  <= out_vld_d;
         out_dat_q  <= out_dat_d;
         out_sof_q  <= out_sof_d;
         out_eof_q  <= out_eof_d;
         sof_next_q <= sof_next_d;
      end
   end

   assign out_vld  = out_vld_q;
   assign out_dat  = out_dat_q;
   assign out_sof  = out_sof_q;
   assign out_eof  = out_eof_q;
   assign drop_cnt = drop_cnt_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Self-checking bench for eth_rx_frame_fifo: scoreboard of expected output
// bytes, a table of frame scenarios, and hand-written corner-case sequences.
module tb_eth_rx_frame_fifo;

   logic        clk_mac = 1'b0;
   logic        rst = 1'b1;
   logic        in_vld = 1'b0;
   logic [7:0]  in_dat = '0;
   logic        in_sof = 1'b0;
   logic        in_eof = 1'b0;
   logic        in_err = 1'b0;
   logic        out_vld;
   logic [7:0]  out_dat;
   logic        out_sof;
   logic        out_eof;
   logic        out_rdy = 1'b0;
   logic [15:0] drop_cnt;
   logic        ovf;

   // Small instance for counter saturation
   logic        s_vld = 1'b0;
   logic [7:0]  s_dat = '0;
   logic        s_sof = 1'b0;
   logic        s_eof = 1'b0;
   logic        s_err = 1'b0;
   logic        s_rdy = 1'b1;
   logic        s_ovld;
   logic [7:0]  s_odat;
   logic        s_osof;
   logic        s_oeof;
   logic [1:0]  s_drop;
   logic        s_ovf;

   eth_rx_frame_fifo #(.ADDR_W(12), .CNT_W(16)) dut (
      .clk_mac(clk_mac), .rst(rst),
      .in_vld(in_vld), .in_dat(in_dat), .in_sof(in_sof), .in_eof(in_eof), .in_err(in_err),
      .out_vld(out_vld), .out_dat(out_dat), .out_sof(out_sof), .out_eof(out_eof),
      .out_rdy(out_rdy), .drop_cnt(drop_cnt), .ovf(ovf)
   );

   eth_rx_frame_fifo #(.ADDR_W(4), .CNT_W(2)) u_small (
      .clk_mac(clk_mac), .rst(rst),
      .in_vld(s_vld), .in_dat(s_dat), .in_sof(s_sof), .in_eof(s_eof), .in_err(s_err),
      .out_vld(s_ovld), .out_dat(s_odat), .out_sof(s_osof), .out_eof(s_oeof),
      .out_rdy(s_rdy), .drop_cnt(s_drop), .ovf(s_ovf)
   );

   always #5 clk_mac = ~clk_mac;

   int          checks = 0;
   int          errors = 0;
   int          ovf_cnt = 0;
   int          frames_out = 0;
   logic [9:0]  sb [$];
   logic [9:0]  mon_exp;
   logic        stall_prev = 1'b0;
   logic [10:0] stall_val = '0;
   logic        rnd_rdy = 1'b0;

   typedef struct {
      int len;
      bit err;
      int exp_drop;
   } vec_t;
   vec_t vecs [8];

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, expv, $time);
      end
   endfunction

   task automatic tick();
      @(posedge clk_mac);
      #1;
   endtask

   // Output monitor: pops expected bytes on accepted transfers, checks stall hold
   always @(negedge clk_mac) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) chk("stall_hold", 32'({out_vld, out_sof, out_eof, out_dat}), 32'(stall_val));
         if (ovf) ovf_cnt++;
         if (out_vld && out_rdy) begin
            if (sb.size() == 0) begin
               chk("unexpected_byte", 32'({out_sof, out_eof, out_dat}), 32'h7ff);
            end else begin
               mon_exp = sb.pop_front();
               chk("out_byte", 32'({out_sof, out_eof, out_dat}), 32'(mon_exp));
            end
            if (out_eof) frames_out++;
         end
         stall_prev = out_vld && !out_rdy;
         stall_val  = {out_vld, out_sof, out_eof, out_dat};
      end
   end

   // Random consumer backpressure
   always @(posedge clk_mac) begin
      if (rnd_rdy) begin
         #1;
         out_rdy = 1'($urandom_range(0, 1));
      end
   end

   task automatic send_frame(input int len, input bit bad, input bit has_eof,
                             input int gap_pct, input bit push);
      for (int i = 0; i < len; i++) begin
         logic [7:0] d;
         while ($urandom_range(0, 99) < gap_pct) begin
            in_vld = 1'b0;
            tick();
         end
         d = 8'($urandom);
         in_vld = 1'b1;
         in_dat = d;
         in_sof = (i == 0);
         in_eof = has_eof && (i == len - 1);
         in_err = bad && has_eof && (i == len - 1);
         if (push) sb.push_back({in_sof, in_eof, d});
         tick();
      end
      in_vld = 1'b0;
      in_sof = 1'b0;
      in_eof = 1'b0;
      in_err = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0 || out_vld) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_done", 32'(sb.size() == 0 && !out_vld), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_vld = 1'b0;
      repeat (2) tick();
      sb.delete();
      rst = 1'b0;
      ovf_cnt = 0;
      frames_out = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int nbad;
      vecs[0] = '{64, 1'b0, 0};
      vecs[1] = '{12, 1'b1, 1};
      vecs[2] = '{10, 1'b0, 1};
      vecs[3] = '{1,  1'b0, 1};
      vecs[4] = '{1,  1'b1, 2};
      vecs[5] = '{2,  1'b0, 2};
      vecs[6] = '{33, 1'b1, 3};
      vecs[7] = '{17, 1'b0, 3};

      // Reset state
      repeat (2) tick();
      chk("rst_outputs", 32'({out_vld, out_sof, out_eof, out_dat, ovf}), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_outputs", 32'({out_vld, out_sof, out_eof, out_dat, ovf}), 32'd0);

      // Counter saturation on the small instance (bad two-byte frames)
      for (int k = 0; k < 5; k++) begin
         s_vld = 1'b1; s_sof = 1'b1; s_eof = 1'b0; s_err = 1'b0; s_dat = 8'(k);
         tick();
         s_sof = 1'b0; s_eof = 1'b1; s_err = 1'b1;
         tick();
         s_vld = 1'b0; s_eof = 1'b0; s_err = 1'b0;
         if (k == 1) chk("sat_drop_2", 32'(s_drop), 32'd2);
         if (k == 2) chk("sat_drop_3", 32'(s_drop), 32'd3);
      end
      repeat (4) tick();
      chk("sat_drop_hold", 32'(s_drop), 32'd3);
      chk("sat_no_output", 32'({s_ovld, s_osof, s_oeof, s_odat, s_ovf}), 32'd0);

      // 64-byte good frame: out_vld two cycles after the eof edge
      do_reset();
      out_rdy = 1'b1;
      send_frame(64, 1'b0, 1'b1, 0, 1'b1);
      @(negedge clk_mac);
      chk("lat_edge0", 32'(out_vld), 32'd0);
      @(negedge clk_mac);
      chk("lat_edge1", 32'(out_vld), 32'd0);
      @(negedge clk_mac);
      chk("lat_edge2", 32'(out_vld), 32'd1);
      chk("lat_sof", 32'(out_sof), 32'd1);
      #1;
      wait_drain(500);
      chk("lat_frames", 32'(frames_out), 32'd1);
      chk("lat_drop", 32'(drop_cnt), 32'd0);

      // Table of frame scenarios with cumulative drop count
      do_reset();
      out_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send_frame(vecs[i].len, vecs[i].err, 1'b1, 20, !vecs[i].err);
         wait_drain(2000);
         chk($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].exp_drop));
      end
      chk("vec_ovf", 32'(ovf_cnt), 32'd0);

      // Missing eof: 20-byte partial frame then a 30-byte frame
      do_reset();
      out_rdy = 1'b1;
      send_frame(20, 1'b0, 1'b0, 0, 1'b0);
      send_frame(30, 1'b0, 1'b1, 0, 1'b1);
      wait_drain(500);
      chk("trunc_drop", 32'(drop_cnt), 32'd1);
      chk("trunc_frames", 32'(frames_out), 32'd1);

      // Overflow: 68 x 60-byte frames fit, the 69th is dropped
      do_reset();
      out_rdy = 1'b0;
      for (int f = 0; f < 69; f++) send_frame(60, 1'b0, 1'b1, 0, f < 68);
      repeat (2) tick();
      chk("ovf_pulses", 32'(ovf_cnt), 32'd1);
      chk("ovf_drop", 32'(drop_cnt), 32'd1);
      chk("ovf_vld_stalled", 32'(out_vld), 32'd1);
      out_rdy = 1'b1;
      wait_drain(10000);
      repeat (10) tick();
      chk("ovf_frames", 32'(frames_out), 32'd68);
      send_frame(60, 1'b0, 1'b1, 0, 1'b1);
      wait_drain(500);
      chk("ovf_recover_frames", 32'(frames_out), 32'd69);

      // Reset mid-frame while a prior frame sits at the output
      do_reset();
      out_rdy = 1'b0;
      send_frame(10, 1'b0, 1'b1, 0, 1'b1);
      repeat (4) tick();
      chk("prerst_vld", 32'(out_vld), 32'd1);
      for (int i = 0; i < 6; i++) begin
         in_vld = 1'b1; in_dat = 8'(i + 8'h40); in_sof = (i == 0); in_eof = 1'b0;
         if (i < 5) tick();
      end
      #2;
      rst = 1'b1;
      #1;
      chk("rst_vld", 32'(out_vld), 32'd0);
      chk("rst_sof_eof", 32'({out_sof, out_eof}), 32'd0);
      chk("rst_dat", 32'(out_dat), 32'd0);
      chk("rst_drop_ovf", 32'({drop_cnt, ovf}), 32'd0);
      sb.delete();
      in_vld = 1'b0; in_sof = 1'b0;
      tick();
      rst = 1'b0;
      frames_out = 0;
      out_rdy = 1'b1;
      send_frame(10, 1'b0, 1'b1, 0, 1'b1);
      wait_drain(500);
      chk("postrst_frames", 32'(frames_out), 32'd1);
      chk("postrst_drop", 32'(drop_cnt), 32'd0);

      // Random traffic with random backpressure
      do_reset();
      nbad = 0;
      rnd_rdy = 1'b1;
      for (int f = 0; f < 1000; f++) begin
         int len;
         bit bad;
         len = int'($urandom_range(1, 20));
         bad = ($urandom_range(0, 3) == 0);
         if (bad) nbad++;
         send_frame(len, bad, 1'b1, 60, !bad);
         repeat ($urandom_range(0, 3)) tick();
      end
      rnd_rdy = 1'b0;
      repeat (2) tick();
      out_rdy = 1'b1;
      wait_drain(10000);
      chk("rnd_drop", 32'(drop_cnt), 32'(nbad));
      chk("rnd_ovf", 32'(ovf_cnt), 32'd0);
      chk("rnd_frames", 32'(frames_out), 32'(1000 - nbad));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/eth_rx_frame_fifo.md
ETH_RX_FRAME_FIFO -- requirements
Module: eth_rx_frame_fifo

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning log2 of buffer depth in bytes (4096).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the dropped-frame counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk_mac  input  1  sole clock, 50 MHz RMII MAC clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_vld  input  1  receive byte strobe from the MAC receive stage.
REQ-007 in_dat  input  8  receive byte.
REQ-008 in_sof  input  1  qualifies first byte of a frame (valid with in_vld).
REQ-009 in_eof  input  1  qualifies last byte of a frame (valid with in_vld).
REQ-010 in_err  input  1  frame bad (FCS/PHY error); sampled with the in_eof byte.
REQ-011 out_vld  output  1  out_dat/out_sof/out_eof hold a valid byte.
REQ-012 out_dat  output  8  buffered byte.
REQ-013 out_sof  output  1  first byte of a committed frame.
REQ-014 out_eof  output  1  last byte of a committed frame.
REQ-015 out_rdy  input  1  consumer accepts the byte when out_vld and out_rdy are both high.
REQ-016 drop_cnt  output  CNT_W  count of discarded frames, saturating.
REQ-017 ovf  output  1  one-cycle pulse when a frame is dropped for lack of space.

Function
REQ-018 SHALL store each byte in a 2^ADDR_W x 9 RAM as {eof flag, data}; the sof flag is implied by the preceding eof.
REQ-019 SHALL use these pointers, each ADDR_W+1 bits with a wrap bit: wr_ptr, cmt_ptr (committed end) and rd_ptr.
REQ-020 Full SHALL be declared when wr_ptr - rd_ptr == 2^ADDR_W.
REQ-021 The write FSM SHALL have three states: IDLE, RECV and DROP.
REQ-022 In IDLE, a byte with in_vld & in_sof SHALL be written and move the FSM to RECV; in_vld without in_sof SHALL be ignored.
REQ-023 In RECV, each in_vld byte SHALL be written and wr_ptr SHALL be incremented.
REQ-024 In RECV, on in_vld & in_eof & !in_err: write the byte with the eof flag set, set cmt_ptr <= wr_ptr+1 on the same edge, and return to IDLE.
REQ-025 In RECV, on in_vld & in_eof & in_err: set wr_ptr <= cmt_ptr, increment drop_cnt, and return to IDLE.
REQ-026 In RECV, an in_vld & in_sof byte (previous frame missing its eof) SHALL drop the partial frame: rewind, increment drop_cnt, and write this byte as the start of a new frame.
REQ-027 A byte arriving while full SHALL NOT be written; wr_ptr <= cmt_ptr, ovf pulses, drop_cnt increments, and the FSM enters DROP.
REQ-028 A single-byte frame (in_sof & in_eof on the same byte) arriving in IDLE SHALL be handled as a complete frame in one cycle.
REQ-029 In DROP, the FSM SHALL discard bytes until an in_vld & in_eof byte, then return to IDLE with no further drop_cnt increment.
REQ-030 In DROP, an in_sof byte SHALL be treated as in IDLE.
REQ-031 drop_cnt SHALL saturate at all-ones.
REQ-032 On the read side, out_vld SHALL be high only while rd_ptr != cmt_ptr; uncommitted bytes SHALL never be presented.
REQ-033 Output SHALL be a registered RAM read with one prefetch stage.
REQ-034 out_vld SHALL assert exactly 2 cycles after the edge that samples a good eof byte, when the output was empty.
REQ-035 With out_rdy held high, the read side SHALL sustain 1 byte per cycle.
REQ-036 out_dat/out_sof/out_eof SHALL hold stable while out_vld & !out_rdy.
REQ-037 out_sof SHALL be high on the first byte after reset and on the byte after each out_eof byte.
REQ-038 A simultaneous write commit and read in the same cycle SHALL both take effect; full/empty SHALL be evaluated from pre-edge pointers.

Reset
REQ-039 rst high SHALL immediately clear wr_ptr, cmt_ptr, rd_ptr, drop_cnt, out_vld, out_sof, out_eof, out_dat and ovf to 0, and set the FSM to IDLE.
REQ-040 RAM contents SHALL NOT require reset.
REQ-041 Reset asserted mid-frame SHALL discard all buffered and partial frames.
REQ-042 After rst deasserts, the first in_sof SHALL be accepted no later than the next cycle.

Verification
REQ-043 Good 64-byte frame with out_rdy=1 -> out_vld rises 2 cycles after the eof edge; 64 contiguous bytes match the input, out_sof on byte 0, out_eof on byte 63; drop_cnt=0.
REQ-044 Frame with in_err=1 on eof, followed by a good 10-byte frame -> only the 10-byte frame is output; drop_cnt=1.
REQ-045 out_rdy=0 while 4100 bytes of 60-byte frames arrive -> 68 frames (4080 B) buffered; the next frame drops with one ovf pulse; drop_cnt=1; out_rdy=1 then drains exactly 68 intact frames.
REQ-046 in_sof arrives mid-frame with no eof (20 B then new 30 B frame) -> only the 30 B frame is output; drop_cnt=1.
REQ-047 rst pulse during byte 5 of a frame and during output of a prior frame -> all outputs 0 in the same cycle; a subsequent good frame is output correctly with out_sof.
REQ-048 Random out_rdy toggling over 1000 random good/bad frames, with simultaneous commit and read -> output equals the good-frame stream in order; outputs stable while stalled.
